// File: rtl/am2950_port.sv
// am2950_port: bidirectional 8-bit-style I/O port with two holding registers
// and handshake flags, modelled on the Am2950 parallel I/O port.
//
// Ports:
//   clk     rising-edge clock for all registers and flags
//   rst_    asynchronous active-low reset
//   a       processor-side bus: loads R, driven from S when oea_=0
//   b       peripheral-side bus: loads S, driven from R when oeb_=0
//   cer_    active-low load enable for R (a -> R)
//   ces_    active-low load enable for S (b -> S)
//   oea_    active-low output enable, S onto a
//   oeb_    active-low output enable, R onto b
//   clrr_   active-low acknowledge from the b side, clears fr
//   clrs_   active-low acknowledge from the a side, clears fs
//   fr, fs  registered "data available" flags for R and S
//   ovrr, ovrs  sticky overrun flags for R and S (cleared only by reset)
module am2950_port #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_,
    inout  wire  [WIDTH-1:0] a,
    inout  wire  [WIDTH-1:0] b,
    input  logic             cer_,
    input  logic             ces_,
    input  logic             oea_,
    input  logic             oeb_,
    input  logic             clrr_,
    input  logic             clrs_,
    output logic             fr,
    output logic             fs,
    output logic             ovrr,
    output logic             ovrs
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] s_q;

    logic fr_d;
    logic fs_d;
    logic ovrr_d;
    logic ovrs_d;

    // Combinational bus drivers; no clock latency between enable and data.
    assign b = oeb_ ? {WIDTH{1'bz}} : r_q;
    assign a = oea_ ? {WIDTH{1'bz}} : s_q;

    // Data registers. Bus values are stored as sampled (Z/X included), and a
    // load always overwrites, even when the previous word was not consumed.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_q <= '0;
            s_q <= '0;
        end else begin
            if (!cer_) r_q <= a;
            if (!ces_) s_q <= b;
        end
    end

    // Flag next-state: a load beats a simultaneous acknowledge, and an
    // overrun is only a load onto unconsumed data that is not being acked.
    always_comb begin
        fr_d   = fr;
        fs_d   = fs;
        ovrr_d = ovrr;
        ovrs_d = ovrs;

        if (!cer_)       fr_d = 1'b1;
        else if (!clrr_) fr_d = 1'b0;

        if (!ces_)       fs_d = 1'b1;
        else if (!clrs_) fs_d = 1'b0;

        if (!cer_ && fr && clrr_) ovrr_d = 1'b1;
        if (!ces_ && fs && clrs_) ovrs_d = 1'b1;
    end

    // Flag registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fr   <= 1'b0;
            fs   <= 1'b0;
            ovrr <= 1'b0;
            ovrs <= 1'b0;
        end else begin
            fr   <= fr_d;
            fs   <= fs_d;
            ovrr <= ovrr_d;
            ovrs <= ovrs_d;
        end
    end

endmodule

// File: doc/am2950_port.md
AM2950_PORT -- requirements
Module: am2950_port

Interface
REQ-001 Parameter: WIDTH, default 8, data path width of both buses and both registers.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all registers and flags.
REQ-004 rst_  input  1  asynchronous active-low reset.
REQ-005 a  inout  WIDTH  processor-side bus; source of register R, driven from register S.
REQ-006 b  inout  WIDTH  peripheral-side bus; source of register S, driven from register R.
REQ-007 cer_  input  1  active-low load enable, register R (A->B).
REQ-008 ces_  input  1  active-low load enable, register S (B->A).
REQ-009 oea_  input  1  active-low output enable, S onto a.
REQ-010 oeb_  input  1  active-low output enable, R onto b.
REQ-011 clrr_  input  1  active-low acknowledge from B side; clears flag fr.
REQ-012 clrs_  input  1  active-low acknowledge from A side; clears flag fs.
REQ-013 fr, fs  output  1 each  registered "data available" flags for R and S.
REQ-014 ovrr, ovrs  output  1 each  sticky overrun flags for R and S.

Function
REQ-015 On a rising clk edge with cer_=0, R SHALL load a; with ces_=0, S SHALL load b. Otherwise each register holds its value.
REQ-016 Data SHALL be non-inverting: b equals R and a equals S when enabled.
REQ-017 b SHALL be R when oeb_=0, else all-Z; a SHALL be S when oea_=0, else all-Z. Both paths are combinational, with no clock latency.
REQ-018 fr next state: set if cer_=0; else cleared if clrr_=0; else hold. Load wins over a simultaneous clear.
REQ-019 fs next state: set if ces_=0; else cleared if clrs_=0; else hold. Load wins over a simultaneous clear.
REQ-020 ovrr SHALL set on an edge with cer_=0, fr=1 and clrr_=1. It is sticky and cleared only by reset. An edge with cer_=0, fr=1 and clrr_=0 SHALL NOT set ovrr.
REQ-021 ovrs SHALL follow REQ-020 using ces_, fs and clrs_.
REQ-022 Flags SHALL update one edge after the controlling input is sampled, and SHALL be visible after that edge.
REQ-023 A load while fr=1 SHALL still overwrite R; newest data wins. The same applies to S.
REQ-024 The R and S channels SHALL be fully independent; simultaneous activity on both channels is legal.
REQ-025 Loopback SHALL be legal:
- cer_=0 with oea_=0 loads R from a, which is driven by S.
- ces_=0 with oeb_=0 loads S from b, which is driven by R.
REQ-026 Z or X bits sampled on a load SHALL be stored as-is; no resolution is performed.

Reset
REQ-027 rst_=0 SHALL immediately force R=0, S=0, fr=0, fs=0, ovrr=0, ovrs=0, independent of clk.
REQ-028 While rst_=0, loads and clears SHALL be ignored.
REQ-029 Bus drive SHALL still follow oea_/oeb_ during reset, driving the zeroed registers.
REQ-030 Reset asserted mid-transfer SHALL abort it; no flag survives the reset.
REQ-031 The first edge after rst_ rises SHALL behave normally.

Verification
REQ-032 Reset, then all enables high, oea_=oeb_=1:
- required response: a=b=ZZZZZZZZ, fr=fs=ovrr=ovrs=0.
REQ-033 A->B transfer:
- stimulus: a=00110011, cer_=0 for one edge, then oeb_=0.
- required response: b=00110011, fr=1 after the edge; clrr_=0 for one edge -> fr=0, ovrr=0.
REQ-034 B->A transfer:
- stimulus: b=01010101, ces_=0 for one edge, then oea_=0.
- required response: a=01010101, fs=1; a second ces_ edge with b=11110000 and no clrs_ -> a=11110000, ovrs=1.
REQ-035 Simultaneous load and clear: fr=1, then one edge with cer_=0, clrr_=0, a=10101010.
- required response: fr=1, ovrr=0, R=10101010.
REQ-036 Async reset mid-operation: fr=fs=ovrr=1, pull rst_ low between edges.
- required response: all flags 0 and enabled buses show 00000000 before the next edge.
REQ-037 Loopback: S=11001100, oea_=0, cer_=0 for one edge, then oeb_=0.
- required response: b=11001100, fr=1.
